mux_frame_scheduler: RTL and testbench
======================================

Name: mux_frame_scheduler

Overview:
- Sequencer for the 16-bit channel mux ahead of the serial transmitter.
- Once per programmable frame period it walks `selector` through channels 0..NUM_CH-1.
- For each channel it issues a `data_lock` strobe so the mux captures that channel, then hands the word to the serial TX through a start/busy handshake.
- Reports frame completion and frame-period overruns.

Parameters:
- NUM_CH, 2, number of mux channels scanned per frame (1..256).
- SEL_W, 8, width of `selector` output.
- LOCK_W, 2, cycles `data_lock` is held high per channel (>=1).
- PER_W, 16, width of `period` input and the period counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- enable  in  1  1 = period counter runs and frames are launched.
- period  in  PER_W  frame period in clk cycles; 0 and 1 both mean a tick every cycle.
- tx_busy  in  1  serial TX busy flag.
- err_clr  in  1  synchronous clear of `ovr_err`.
- selector  out  SEL_W  channel index driven to the mux.
- data_lock  out  1  capture strobe to the mux; the mux latches on its rising edge.
- tx_start  out  1  transmit request to the serial TX.
- frame_done  out  1  one-cycle pulse after the last channel's transfer completes.
- ovr_err  out  1  sticky; a frame tick arrived while a frame was still in progress.
- busy  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, async): all outputs 0, selector=0, channel counter=0, period counter=0, FSM=IDLE.
- Period counter:
  - Counts 0..period-1 while enable=1.
  - tick=1 in the cycle count==period-1; the counter wraps to 0 on that cycle.
  - enable=0 holds the counter at 0 and suppresses ticks.
  - A change to `period` takes effect at the next wrap. If the count is already >= the new period-1, it wraps on the next cycle.
- FSM states: IDLE, SETUP, LOCK, GAP, SEND, WAIT, NEXT.
- IDLE:
  - On tick: channel counter <- 0, go to SETUP.
  - Otherwise remain in IDLE.
- SETUP (1 cycle): selector <- channel counter; data_lock=0. Selector is therefore stable one cycle before the strobe rises.
- LOCK (LOCK_W cycles): data_lock=1, selector held.
- GAP (1 cycle):
  - data_lock=0. This guarantees a fresh rising edge for the next channel and gives the mux output one cycle to settle.
  - Go to SEND.
- SEND:
  - tx_start=1, held until tx_busy=1 is sampled; in that cycle tx_start drops to 0 and the FSM moves to WAIT.
  - If tx_busy is already 1 on entry, the FSM waits in SEND for tx_busy=0 first, then raises tx_start. A transfer is never requested over a busy TX.
- WAIT: remain until tx_busy=0, then go to NEXT.
- NEXT (1 cycle):
  - If channel counter == NUM_CH-1: frame_done=1 for this cycle, go to IDLE.
  - Else: increment the channel counter, go to SETUP.
- selector holds its last value in IDLE (it is not returned to 0).
- Minimum per-channel latency SETUP→NEXT: 1+LOCK_W+1+1+1+1 cycles, with the TX asserting busy the cycle after tx_start and releasing it the following cycle.
- Overrun: a tick while FSM != IDLE sets ovr_err=1. The tick is dropped and the current frame continues unaffected.
- err_clr=1 clears ovr_err. A simultaneous overrun set wins.
- enable deasserted mid-frame: the current frame completes normally, including frame_done; no further frames launch.
- Reset mid-frame: the FSM aborts to IDLE immediately and data_lock and tx_start drop asynchronously.
- Channel counter width is SEL_W. Only values 0..NUM_CH-1 are ever driven; no wrap beyond NUM_CH-1.

Test Plan:
- Reset, then enable=1, period=100, NUM_CH=2, TX model asserts busy 1 cycle after start for 10 cycles:
  - selector 0 then 1.
  - Exactly two data_lock pulses, each LOCK_W=2 cycles wide.
  - Two tx_start handshakes.
  - frame_done pulses once per 100-cycle frame.
  - ovr_err stays 0.
- period=10 with TX busy for 20 cycles:
  - Ticks arriving during the frame set ovr_err=1; the frame still finishes with selector 0→1.
  - err_clr pulse returns ovr_err to 0, except when a tick coincides with err_clr, in which case ovr_err stays 1.
- tx_busy held 1 before SEND: tx_start stays 0 until tx_busy falls, then asserts the next cycle.
- enable dropped while in WAIT for channel 0: channel 1 is still processed and frame_done pulses; no new frame after 3×period idle cycles.
- reset=0 asserted during LOCK: data_lock, tx_start and busy go 0 without a clock edge; after release, the first frame starts from selector=0.
- period=0 and period=1: ticks every cycle. The first frame launches one cycle after enable; subsequent ticks during the frame set ovr_err.

Source files
------------

// File: rtl/mux_frame_scheduler.sv
// Frame scheduler for the 16-bit channel mux ahead of the serial transmitter.
// Once per frame period it steps the mux selector through every channel,
// strobes data_lock so the mux captures the channel, then hands the word to
// the serial TX through a start/busy handshake.
module mux_frame_scheduler #(
  parameter int NUM_CH = 2,
  parameter int SEL_W  = 8,
  parameter int LOCK_W = 2,
  parameter int PER_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [PER_W-1:0] period,
  input  logic             tx_busy,
  input  logic             err_clr,
  output logic [SEL_W-1:0] selector,
  output logic             data_lock,
  output logic             tx_start,
  output logic             frame_done,
  output logic             ovr_err,
  output logic             busy
);

  localparam int               LCW       = (LOCK_W > 1) ? $clog2(LOCK_W) : 1;
  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CH - 1);
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOCK, S_GAP, S_SEND, S_WAIT, S_NEXT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PER_W-1:0] r_cnt;
  logic [PER_W-1:0] w_per_last;
  logic             w_tick;
  logic [SEL_W-1:0] r_ch;
  logic [LCW-1:0]   r_lcnt;
  logic             r_armed;
  logic             r_ovr;

  // Period 0 and 1 both collapse to a terminal count of 0 (tick every cycle).
  // Using >= lets a shortened period take effect on the very next cycle.
  assign w_per_last = (period > PER_W'(1)) ? (period - PER_W'(1)) : '0;
  assign w_tick     = enable && (r_cnt >= w_per_last);

  // The channel counter doubles as the selector: it is loaded on entry to
  // SETUP, so the mux address settles a cycle before data_lock rises.
  assign selector = r_ch;
  assign busy     = (r_state != S_IDLE);
  assign ovr_err  = r_ovr;

  // Frame period counter; held at zero while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_cnt <= '0;
    else if (!enable || w_tick) r_cnt <= '0;
    else                        r_cnt <= r_cnt + PER_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    data_lock   = 1'b0;
    tx_start    = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      S_IDLE:  if (w_tick) w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = S_LOCK;
      S_LOCK: begin
        data_lock = 1'b1;
        if (r_lcnt == LOCK_LAST) w_state_nxt = S_GAP;
      end
      S_GAP:   w_state_nxt = S_SEND;
      S_SEND: begin
        tx_start = r_armed;
        if (r_armed && tx_busy) w_state_nxt = S_WAIT;
      end
      S_WAIT:  if (!tx_busy) w_state_nxt = S_NEXT;
      S_NEXT: begin
        if (r_ch == LAST_CH) begin
          frame_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_SETUP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Channel counter, lock-width timer and the SEND arm flag. The arm flag is
  // only set once the TX is seen idle, so a request never overlaps a busy TX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ch    <= '0;
      r_lcnt  <= '0;
      r_armed <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_tick)
        r_ch <= '0;
      else if (r_state == S_NEXT && r_ch != LAST_CH)
        r_ch <= r_ch + SEL_W'(1);

      if (r_state == S_LOCK) r_lcnt <= r_lcnt + LCW'(1);
      else                   r_lcnt <= '0;

      if (r_state == S_GAP)
        r_armed <= !tx_busy;
      else if (r_state == S_SEND && !r_armed && !tx_busy)
        r_armed <= 1'b1;
    end
  end

  // Sticky overrun flag; a new overrun wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            r_ovr <= 1'b0;
    else if (w_tick && r_state != S_IDLE)  r_ovr <= 1'b1;
    else if (err_clr)                      r_ovr <= 1'b0;
  end

endmodule

// File: tb/tb_mux_frame_scheduler.sv
// Directed bench for mux_frame_scheduler with a small serial-TX busy model.
module tb_mux_frame_scheduler;

  localparam int NUM_CH = 2;
  localparam int SEL_W  = 8;
  localparam int LOCK_W = 2;
  localparam int PER_W  = 16;

  localparam int SIG_LOCK = 0;
  localparam int SIG_TXS  = 1;
  localparam int SIG_DONE = 2;
  localparam int SIG_BUSY = 3;
  localparam int SIG_TXB  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [PER_W-1:0] period;
  logic             tx_busy;
  logic             err_clr;
  logic [SEL_W-1:0] selector;
  logic             data_lock;
  logic             tx_start;
  logic             frame_done;
  logic             ovr_err;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  logic tx_auto;
  int   tx_len;
  int   tx_cnt = 0;

  always #5 clk = ~clk;

  mux_frame_scheduler #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .LOCK_W(LOCK_W), .PER_W(PER_W)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .tx_busy(tx_busy), .err_clr(err_clr), .selector(selector),
    .data_lock(data_lock), .tx_start(tx_start), .frame_done(frame_done),
    .ovr_err(ovr_err), .busy(busy)
  );

  // TX model: raises busy the cycle after it sees tx_start, holds it tx_len cycles.
  initial begin
    logic pend;
    forever begin
      @(negedge clk);
      pend = tx_auto && tx_start && !tx_busy && (tx_cnt == 0);
      @(posedge clk);
      #1;
      if (tx_auto) begin
        if (pend) begin
          tx_busy = 1'b1;
          tx_cnt  = tx_len;
        end else if (tx_cnt > 0) begin
          tx_cnt = tx_cnt - 1;
          if (tx_cnt == 0) tx_busy = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig_of(input int s);
    case (s)
      SIG_LOCK: return data_lock;
      SIG_TXS:  return tx_start;
      SIG_DONE: return frame_done;
      SIG_BUSY: return busy;
      SIG_TXB:  return tx_busy;
      default:  return ovr_err;
    endcase
  endfunction

  // Called at a negedge; waits up to lim cycles for the signal to reach v.
  task automatic wait_until(input string tag, input int s, input logic v, input int lim);
    int n;
    n = 0;
    while (sig_of(s) !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sig_of(s)), 32'(v));
  endtask

  initial begin
    int lock_rises, start_rises, done_cnt, f1, f2, wmin, wmax, w, stable_bad, busy_cyc;
    logic pl, ps, ovr_seen;
    logic [SEL_W-1:0] psel;
    logic [SEL_W-1:0] sels [4];

    reset = 1'b0; enable = 1'b0; period = 16'd100; tx_busy = 1'b0;
    err_clr = 1'b0; tx_auto = 1'b1; tx_len = 10;
    repeat (3) @(negedge clk);
    chk("rst_selector",   32'(selector),   32'd0);
    chk("rst_data_lock",  32'(data_lock),  32'd0);
    chk("rst_tx_start",   32'(tx_start),   32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_ovr_err",    32'(ovr_err),    32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two frames at period 100, TX busy 10 cycles.
    enable = 1'b1;
    lock_rises = 0; start_rises = 0; done_cnt = 0; f1 = -1; f2 = -1;
    wmin = 99; wmax = 0; w = 0; stable_bad = 0; ovr_seen = 1'b0;
    pl = 1'b0; ps = 1'b0; psel = selector;
    for (int i = 0; i < 4; i++) sels[i] = '1;
    for (int k = 0; k < 245; k++) begin
      @(negedge clk);
      if (data_lock && !pl) begin
        if (lock_rises < 4) sels[lock_rises] = selector;
        if (selector !== psel) stable_bad++;
        lock_rises++;
      end
      if (data_lock) w++;
      else if (pl) begin
        if (w < wmin) wmin = w;
        if (w > wmax) wmax = w;
        w = 0;
      end
      if (tx_start && !ps) start_rises++;
      if (frame_done) begin
        if (f1 < 0) f1 = k;
        else if (f2 < 0) f2 = k;
        done_cnt++;
      end
      if (ovr_err) ovr_seen = 1'b1;
      pl = data_lock; ps = tx_start; psel = selector;
    end
    chk("t1_lock_pulses", 32'(lock_rises), 32'd4);
    chk("t1_lock_wmin",   32'(wmin), 32'd2);
    chk("t1_lock_wmax",   32'(wmax), 32'd2);
    chk("t1_sel0",        32'(sels[0]), 32'd0);
    chk("t1_sel1",        32'(sels[1]), 32'd1);
    chk("t1_sel2",        32'(sels[2]), 32'd0);
    chk("t1_sel3",        32'(sels[3]), 32'd1);
    chk("t1_sel_stable",  32'(stable_bad), 32'd0);
    chk("t1_tx_starts",   32'(start_rises), 32'd4);
    chk("t1_done_cnt",    32'(done_cnt), 32'd2);
    chk("t1_first_done",  32'(f1), 32'd132);
    chk("t1_done_period", 32'(f2 - f1), 32'd100);
    chk("t1_no_ovr",      32'(ovr_seen), 32'd0);

    // Period 10, TX busy 20: overruns during the frame.
    enable = 1'b0; period = 16'd10; tx_len = 20;
    @(negedge clk);
    enable = 1'b1;
    lock_rises = 0; pl = 1'b0;
    for (int i = 0; i < 4; i++) sels[i] = '1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (data_lock && !pl) begin
        if (lock_rises < 4) sels[lock_rises] = selector;
        lock_rises++;
      end
      pl = data_lock;
      if (frame_done) break;
    end
    chk("t2_frame_done", 32'(frame_done), 32'd1);
    chk("t2_lock_pulses", 32'(lock_rises), 32'd2);
    chk("t2_sel0", 32'(sels[0]), 32'd0);
    chk("t2_sel1", 32'(sels[1]), 32'd1);
    chk("t2_ovr_set", 32'(ovr_err), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_ovr_sticky", 32'(ovr_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t2_ovr_cleared", 32'(ovr_err), 32'd0);

    // TX already busy when SEND is entered.
    tx_auto = 1'b0; tx_busy = 1'b1; period = 16'd5; tx_len = 10;
    @(negedge clk);
    enable = 1'b1;
    wait_until("t3_lock_rise", SIG_LOCK, 1'b1, 20);
    enable = 1'b0;
    wait_until("t3_lock_fall", SIG_LOCK, 1'b0, 10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_no_start_busy", 32'(tx_start), 32'd0);
    end
    chk("t3_still_busy", 32'(busy), 32'd1);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("t3_start_after_free", 32'(tx_start), 32'd1);
    tx_busy = 1'b1;
    @(negedge clk);
    chk("t3_start_dropped", 32'(tx_start), 32'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("t3_ch0_not_done", 32'(frame_done), 32'd0);
    tx_auto = 1'b1;
    wait_until("t3_done", SIG_DONE, 1'b1, 60);
    chk("t3_done_sel", 32'(selector), 32'd1);
    @(negedge clk);
    chk("t3_back_idle", 32'(busy), 32'd0);

    // Enable dropped while waiting on channel 0's transfer.
    period = 16'd50;
    @(negedge clk);
    enable = 1'b1;
    wait_until("t4_lock_rise", SIG_LOCK, 1'b1, 70);
    wait_until("t4_tx_busy", SIG_TXB, 1'b1, 20);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    chk("t4_in_ch0", 32'(selector), 32'd0);
    wait_until("t4_done", SIG_DONE, 1'b1, 60);
    chk("t4_done_sel", 32'(selector), 32'd1);
    busy_cyc = 0;
    for (int k = 0; k < 151; k++) begin
      @(negedge clk);
      if (busy || data_lock) busy_cyc++;
    end
    chk("t4_no_new_frame", 32'(busy_cyc), 32'd0);

    // Asynchronous reset during channel 1's lock strobe.
    enable = 1'b1;
    wait_until("t5_lock0", SIG_LOCK, 1'b1, 70);
    wait_until("t5_lock0_fall", SIG_LOCK, 1'b0, 10);
    wait_until("t5_lock1", SIG_LOCK, 1'b1, 40);
    chk("t5_sel_before", 32'(selector), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t5_async_lock", 32'(data_lock), 32'd0);
    chk("t5_async_start", 32'(tx_start), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_sel", 32'(selector), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_until("t5_relaunch", SIG_LOCK, 1'b1, 70);
    chk("t5_first_sel", 32'(selector), 32'd0);
    enable = 1'b0;
    wait_until("t5_idle", SIG_BUSY, 1'b0, 80);

    // Period 0 and 1: tick every cycle.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t6_ovr_clear", 32'(ovr_err), 32'd0);
    chk("t6_pre_idle", 32'(busy), 32'd0);
    period = 16'd0;
    enable = 1'b1;
    @(negedge clk);
    chk("t6_p0_launch", 32'(busy), 32'd1);
    chk("t6_p0_sel", 32'(selector), 32'd0);
    repeat (5) @(negedge clk);
    chk("t6_p0_ovr", 32'(ovr_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t6_clr_vs_tick", 32'(ovr_err), 32'd1);
    enable = 1'b0;
    wait_until("t6_p0_idle", SIG_BUSY, 1'b0, 80);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t6_ovr_clear2", 32'(ovr_err), 32'd0);
    period = 16'd1;
    enable = 1'b1;
    @(negedge clk);
    chk("t6_p1_launch", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    chk("t6_p1_ovr", 32'(ovr_err), 32'd1);
    enable = 1'b0;
    wait_until("t6_p1_idle", SIG_BUSY, 1'b0, 80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
